// File: rtl/assign_label_if.sv
// Distance-sample and result bundle for assign_label; counter signals exist only
// when ASSIGN_LABEL_CNT_EN is defined.
interface assign_label_if #(
  parameter int DOUBLE_WIDTH  = 32,
  parameter int LOG_NUM_LABEL = 3
`ifdef ASSIGN_LABEL_CNT_EN
  ,
  parameter int LOG_DEPTH     = 10
`endif
);
  logic                     enable;
  logic [DOUBLE_WIDTH:0]    dist0;
  logic [DOUBLE_WIDTH:0]    dist1;
  logic [DOUBLE_WIDTH:0]    dist2;
  logic [DOUBLE_WIDTH:0]    dist3;
  logic [DOUBLE_WIDTH:0]    dist4;
  logic [DOUBLE_WIDTH:0]    dist5;
  logic [DOUBLE_WIDTH:0]    dist6;
  logic [DOUBLE_WIDTH:0]    dist7;
  logic [LOG_NUM_LABEL-1:0] label;
  logic [DOUBLE_WIDTH:0]    min_dist;
  logic                     valid_out;

`ifdef ASSIGN_LABEL_CNT_EN
  logic                     clear_cnt;
  logic [LOG_DEPTH:0]       cnt0;
  logic [LOG_DEPTH:0]       cnt1;
  logic [LOG_DEPTH:0]       cnt2;
  logic [LOG_DEPTH:0]       cnt3;
  logic [LOG_DEPTH:0]       cnt4;
  logic [LOG_DEPTH:0]       cnt5;
  logic [LOG_DEPTH:0]       cnt6;
  logic [LOG_DEPTH:0]       cnt7;

  modport master (
    output enable, dist0, dist1, dist2, dist3, dist4, dist5, dist6, dist7, clear_cnt,
    input  label, min_dist, valid_out, cnt0, cnt1, cnt2, cnt3, cnt4, cnt5, cnt6, cnt7
  );
  modport slave (
    input  enable, dist0, dist1, dist2, dist3, dist4, dist5, dist6, dist7, clear_cnt,
    output label, min_dist, valid_out, cnt0, cnt1, cnt2, cnt3, cnt4, cnt5, cnt6, cnt7
  );
`else
  modport master (
    output enable, dist0, dist1, dist2, dist3, dist4, dist5, dist6, dist7,
    input  label, min_dist, valid_out
  );
  modport slave (
    input  enable, dist0, dist1, dist2, dist3, dist4, dist5, dist6, dist7,
    output label, min_dist, valid_out
  );
`endif
endinterface

// File: rtl/assign_label.sv
// Nearest-centre selector: registered input stage plus 3-stage min tree, valid out 3 edges after
// enable is sampled, no backpressure. ASSIGN_LABEL_CNT_EN adds saturating per-label hit counters.
module assign_label #(
  parameter int DOUBLE_WIDTH  = 32,
  parameter int NUM_LABEL     = 8,
  parameter int LOG_NUM_LABEL = 3
`ifdef ASSIGN_LABEL_CNT_EN
  ,
  parameter int LOG_DEPTH     = 10
`endif
) (
  input logic           clk,
  input logic           rst,
  assign_label_if.slave bus
);
  localparam int DW = DOUBLE_WIDTH + 1;

  typedef struct packed {
    logic [DW-1:0]            d;
    logic [LOG_NUM_LABEL-1:0] idx;
  } cand_t;

  // lo always carries the smaller original index, so ties resolve to it
  function automatic cand_t pick(input cand_t lo, input cand_t hi);
    return (hi.d < lo.d) ? hi : lo;
  endfunction

  logic [DW-1:0] w_dist [NUM_LABEL];
  assign w_dist[0] = bus.dist0;
  assign w_dist[1] = bus.dist1;
  assign w_dist[2] = bus.dist2;
  assign w_dist[3] = bus.dist3;
  assign w_dist[4] = bus.dist4;
  assign w_dist[5] = bus.dist5;
  assign w_dist[6] = bus.dist6;
  assign w_dist[7] = bus.dist7;

  cand_t r_s0 [NUM_LABEL];
  cand_t r_s1 [NUM_LABEL/2];
  cand_t r_s2 [NUM_LABEL/4];
  logic  r_v0;
  logic  r_v1;
  logic  r_v2;
  logic  r_v3;
  logic [LOG_NUM_LABEL-1:0] r_label;
  logic [DW-1:0]            r_min;
  cand_t w_fin;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v0 <= 1'b0;
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
    end else begin
      r_v0 <= bus.enable;
      r_v1 <= r_v0;
      r_v2 <= r_v1;
    end
  end

  // Data stages only load behind a valid token; bubbles leave them untouched
  always_ff @(posedge clk) begin
    if (bus.enable) begin
      for (int k = 0; k < NUM_LABEL; k++) begin
        r_s0[k] <= {w_dist[k], LOG_NUM_LABEL'(k)};
      end
    end
    if (r_v0) begin
      for (int k = 0; k < NUM_LABEL/2; k++) begin
        r_s1[k] <= pick(r_s0[2*k], r_s0[2*k+1]);
      end
    end
    if (r_v1) begin
      for (int k = 0; k < NUM_LABEL/4; k++) begin
        r_s2[k] <= pick(r_s1[2*k], r_s1[2*k+1]);
      end
    end
  end

  assign w_fin = pick(r_s2[0], r_s2[1]);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v3    <= 1'b0;
      r_label <= '0;
      r_min   <= '0;
    end else begin
      r_v3 <= r_v2;
      if (r_v2) begin
        r_label <= w_fin.idx;
        r_min   <= w_fin.d;
      end
    end
  end

  assign bus.valid_out = r_v3;
  assign bus.label     = r_label;
  assign bus.min_dist  = r_min;

`ifdef ASSIGN_LABEL_CNT_EN
  localparam int CNT_W = LOG_DEPTH + 1;

  logic [CNT_W-1:0] r_cnt [NUM_LABEL];

  // clear beats a coincident increment; counters stick at all-ones
  always_ff @(posedge clk) begin
    if (rst || bus.clear_cnt) begin
      for (int k = 0; k < NUM_LABEL; k++) begin
        r_cnt[k] <= '0;
      end
    end else if (r_v3 && (r_cnt[r_label] != {CNT_W{1'b1}})) begin
      r_cnt[r_label] <= r_cnt[r_label] + CNT_W'(1);
    end
  end

  assign bus.cnt0 = r_cnt[0];
  assign bus.cnt1 = r_cnt[1];
  assign bus.cnt2 = r_cnt[2];
  assign bus.cnt3 = r_cnt[3];
  assign bus.cnt4 = r_cnt[4];
  assign bus.cnt5 = r_cnt[5];
  assign bus.cnt6 = r_cnt[6];
  assign bus.cnt7 = r_cnt[7];
`endif
endmodule

// File: tb/tb_assign_label.sv
// Bench for assign_label: directed vector table, back-to-back, reset and random streams
// checked every cycle against a queue-based latency model.
module tb_assign_label;
  localparam logic [32:0] MAXD = 33'h1_FFFF_FFFF;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  assign_label_if bus ();

  assign_label dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    bit          vld;
    logic [2:0]  lab;
    logic [32:0] mn;
  } exp_t;

  typedef struct packed {
    logic [7:0][32:0] d;
    logic [2:0]       lab;
    logic [32:0]      mn;
  } vec_t;

  int n_err = 0;
  int n_chk = 0;

  logic [32:0] cur_d [8];
  exp_t        q [$];
  bit          m_vld = 1'b0;
  logic [2:0]  m_lab = '0;
  logic [32:0] m_min = '0;
`ifdef ASSIGN_LABEL_CNT_EN
  bit          cur_clr = 1'b0;
  int          m_cnt [8];
`endif

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0][32:0] mk(input logic [32:0] a0, a1, a2, a3, a4, a5, a6, a7);
    logic [7:0][32:0] r;
    r[0] = a0; r[1] = a1; r[2] = a2; r[3] = a3;
    r[4] = a4; r[5] = a5; r[6] = a6; r[7] = a7;
    return r;
  endfunction

  // One clock: drive inputs, advance the model across the edge, compare #1 later
  task automatic cycle(input bit en, input bit r);
    exp_t e;
    bus.enable = en;
    rst        = r;
    bus.dist0 = cur_d[0]; bus.dist1 = cur_d[1]; bus.dist2 = cur_d[2]; bus.dist3 = cur_d[3];
    bus.dist4 = cur_d[4]; bus.dist5 = cur_d[5]; bus.dist6 = cur_d[6]; bus.dist7 = cur_d[7];
`ifdef ASSIGN_LABEL_CNT_EN
    bus.clear_cnt = cur_clr;
`endif
    @(posedge clk);
`ifdef ASSIGN_LABEL_CNT_EN
    if (r || cur_clr) begin
      for (int i = 0; i < 8; i++) m_cnt[i] = 0;
    end else if (m_vld && m_cnt[m_lab] < 2047) begin
      m_cnt[m_lab]++;
    end
`endif
    e.vld = en && !r;
    e.lab = 3'd0;
    e.mn  = cur_d[0];
    for (int i = 1; i < 8; i++) begin
      if (cur_d[i] < e.mn) begin
        e.mn  = cur_d[i];
        e.lab = 3'(i);
      end
    end
    q.push_back(e);
    if (r) begin
      foreach (q[i]) q[i].vld = 1'b0;
      m_lab = '0;
      m_min = '0;
    end
    m_vld = 1'b0;
    if (q.size() > 3) begin
      e = q.pop_front();
      m_vld = e.vld;
      if (e.vld) begin
        m_lab = e.lab;
        m_min = e.mn;
      end
    end
    #1;
    chk("valid_out", 64'(bus.valid_out), 64'(m_vld));
    chk("label", 64'(bus.label), 64'(m_lab));
    chk("min_dist", 64'(bus.min_dist), 64'(m_min));
`ifdef ASSIGN_LABEL_CNT_EN
    chk("cnt0", 64'(bus.cnt0), 64'(m_cnt[0]));
    chk("cnt1", 64'(bus.cnt1), 64'(m_cnt[1]));
    chk("cnt2", 64'(bus.cnt2), 64'(m_cnt[2]));
    chk("cnt3", 64'(bus.cnt3), 64'(m_cnt[3]));
    chk("cnt4", 64'(bus.cnt4), 64'(m_cnt[4]));
    chk("cnt5", 64'(bus.cnt5), 64'(m_cnt[5]));
    chk("cnt6", 64'(bus.cnt6), 64'(m_cnt[6]));
    chk("cnt7", 64'(bus.cnt7), 64'(m_cnt[7]));
`endif
  endtask

  initial begin
    vec_t       vecs [9];
    logic [2:0] seen [$];

    vecs[0] = '{d: mk(50, 40, 30, 20, 10, 60, 70, 80), lab: 3'd4, mn: 33'd10};
    vecs[1] = '{d: mk(100, 100, 100, 5, 100, 100, 5, 100), lab: 3'd3, mn: 33'd5};
    vecs[2] = '{d: mk(0, 0, 0, 0, 0, 0, 0, 0), lab: 3'd0, mn: 33'd0};
    vecs[3] = '{d: mk(MAXD, MAXD, MAXD, MAXD, MAXD, MAXD, MAXD, MAXD), lab: 3'd0, mn: MAXD};
    vecs[4] = '{d: mk(MAXD, MAXD, MAXD, MAXD, MAXD, MAXD, MAXD, MAXD - 1), lab: 3'd7,
                mn: 33'd8589934590};
    vecs[5] = '{d: mk(2, 2, 9, 9, 9, 9, 9, 9), lab: 3'd0, mn: 33'd2};
    vecs[6] = '{d: mk(9, 9, 1, 9, 9, 1, 9, 9), lab: 3'd2, mn: 33'd1};
    vecs[7] = '{d: mk(33'h1_0000_0000, 33'h1_0000_0001, 33'h1_0000_0001, 33'h1_0000_0001,
                      33'h1_0000_0001, 33'h0_FFFF_FFFF, 33'h1_0000_0001, 33'h1_0000_0001),
                lab: 3'd5, mn: 33'h0_FFFF_FFFF};
    vecs[8] = '{d: mk(7, 7, 7, 7, 7, 7, 3, 3), lab: 3'd6, mn: 33'd3};

    for (int i = 0; i < 8; i++) cur_d[i] = 33'(i + 1);
`ifdef ASSIGN_LABEL_CNT_EN
    for (int i = 0; i < 8; i++) m_cnt[i] = 0;
`endif

    // Reset with enable high: the enabled samples must never emerge
    cycle(1'b1, 1'b1);
    cycle(1'b1, 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0);

    // Directed table: single-cycle pulse, result exactly three edges later, then held
    for (int v = 0; v < 9; v++) begin
      for (int i = 0; i < 8; i++) cur_d[i] = vecs[v].d[i];
      cycle(1'b1, 1'b0);
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0);
      chk($sformatf("vec%0d valid", v), 64'(bus.valid_out), 64'd1);
      chk($sformatf("vec%0d label", v), 64'(bus.label), 64'(vecs[v].lab));
      chk($sformatf("vec%0d min", v), 64'(bus.min_dist), 64'(vecs[v].mn));
      cycle(1'b0, 1'b0);
      chk($sformatf("vec%0d hold", v), 64'(bus.label), 64'(vecs[v].lab));
    end

    // Back-to-back: minimum walks across indices 0..7
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < 8; i++) cur_d[i] = 33'd100;
      cur_d[k] = 33'(k + 1);
      cycle(1'b1, 1'b0);
      if (bus.valid_out) seen.push_back(bus.label);
    end
    for (int k = 0; k < 5; k++) begin
      cycle(1'b0, 1'b0);
      if (bus.valid_out) seen.push_back(bus.label);
    end
    chk("b2b count", 64'(seen.size()), 64'd8);
    for (int k = 0; k < 8 && k < seen.size(); k++) begin
      chk($sformatf("b2b label%0d", k), 64'(seen[k]), 64'(k));
    end

    // Reset while two samples are in flight
    for (int i = 0; i < 8; i++) cur_d[i] = 33'(20 - i);
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b1);
    chk("rst label", 64'(bus.label), 64'd0);
    chk("rst min", 64'(bus.min_dist), 64'd0);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b0);
      chk("rst flush", 64'(bus.valid_out), 64'd0);
    end

`ifdef ASSIGN_LABEL_CNT_EN
    // Saturation on label 2, then clear colliding with a live increment
    for (int i = 0; i < 8; i++) cur_d[i] = 33'd1;
    cur_d[2] = 33'd0;
    for (int i = 0; i < 2100; i++) cycle(1'b1, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0);
    chk("cnt2 saturated", 64'(bus.cnt2), 64'd2047);
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0);
    chk("clear precondition", 64'(bus.valid_out), 64'd1);
    cur_clr = 1'b1;
    cycle(1'b0, 1'b0);
    cur_clr = 1'b0;
    chk("clear cnt2", 64'(bus.cnt2), 64'd0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0);
`endif

    // Random stream: mixed narrow (tie-heavy) and full-width distances, sparse resets
    for (int n = 0; n < 800; n++) begin
      bit narrow;
      narrow = ($urandom_range(0, 1) == 1);
      for (int i = 0; i < 8; i++) begin
        if (narrow) cur_d[i] = 33'($urandom_range(0, 7));
        else cur_d[i] = {1'($urandom_range(0, 1)), 32'($urandom)};
      end
`ifdef ASSIGN_LABEL_CNT_EN
      cur_clr = ($urandom_range(0, 49) == 0);
`endif
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 59) == 0);
    end
`ifdef ASSIGN_LABEL_CNT_EN
    cur_clr = 1'b0;
`endif
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/assign_label.md
ASSIGN_LABEL -- requirements
Module: assign_label

Interface
REQ-001 Compile-time constant DOUBLE_WIDTH, default 32: distance-square width; distance ports are DOUBLE_WIDTH+1 bits.
REQ-002 Compile-time constant NUM_LABEL, default 8: number of cluster centres.
REQ-003 Compile-time constant LOG_NUM_LABEL, default 3: label width.
REQ-004 Compile-time constant LOG_DEPTH, default 10: log2 of point-memory depth; counter width is LOG_DEPTH+1.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 enable  input  1  qualifies dist0..dist7 as a valid sample this cycle.
REQ-008 dist0..dist7  input  33 each  squared Euclidean distance from the current point to centres 0..7, unsigned.
REQ-009 clear_cnt  input  1  synchronous clear of all label counters.
REQ-010 label  output  3  index of the nearest centre.
REQ-011 min_dist  output  33  distance value of the winning centre.
REQ-012 valid_out  output  1  label and min_dist are valid this cycle.
REQ-013 cnt0..cnt7  output  11 each  points assigned per label since the last clear (LABEL_CNT_EN only).

Function
REQ-014 The block SHALL implement a 3-stage registered comparator tree: stage 1 compares pairs (0,1), (2,3), (4,5) and (6,7); stage 2 compares the stage-1 winners pairwise; stage 3 compares the two stage-2 winners into the label and min_dist registers.
REQ-015 Each stage SHALL carry the candidate distance plus its original 3-bit index.
REQ-016 Comparison SHALL be unsigned over all 33 bits; on a tie, the lower index SHALL win at every stage.
REQ-017 Latency SHALL be exactly 3 cycles: enable sampled high at edge N gives valid_out=1 with the corresponding label/min_dist after edge N+3.
REQ-018 Throughput SHALL be one sample per cycle with no backpressure; enable may be high on consecutive cycles.
REQ-019 A valid bit SHALL shift alongside the data; enable low inserts a bubble that emerges as valid_out=0 three cycles later.
REQ-020 When valid_out=0, label and min_dist SHALL hold their last valid values.
REQ-021 All-equal inputs (including all zero or all 2^33-1) SHALL yield label=0.

Reset
REQ-022 When rst=1 at a clock edge, all pipeline valid bits, valid_out, label, min_dist and cnt0..cnt7 SHALL be 0 after that edge.
REQ-023 Reset asserted mid-stream SHALL discard all in-flight samples; no valid_out for them after rst deasserts.
REQ-024 enable high in the same cycle as rst SHALL be ignored.

Configuration
REQ-025 Macro ASSIGN_LABEL_CNT_EN: when defined, cnt0..cnt7 exist; each cycle with valid_out=1, cnt[label] increments by 1.
REQ-026 With ASSIGN_LABEL_CNT_EN defined, counters SHALL saturate at 2047 and not wrap.
REQ-027 With ASSIGN_LABEL_CNT_EN defined, clear_cnt=1 SHALL zero all counters at that edge; if a valid_out increment coincides, clear wins and that assignment is not counted.
REQ-028 Without ASSIGN_LABEL_CNT_EN, cnt0..cnt7 and clear_cnt SHALL be absent from the port list, and no counter logic shall exist; all other behaviour is identical.

Verification
REQ-029 dist0..7 = 50,40,30,20,10,60,70,80 with enable pulsed 1 cycle -> valid_out=1 exactly 3 cycles later, label=4, min_dist=10.
REQ-030 dist3=dist6=5, all other distances 100 -> label=3 (tie goes to lower index); all distances 0 -> label=0.
REQ-031 8 back-to-back samples, each with its minimum at index k=0..7 and enable held high, then enable low -> 8 consecutive valid_out cycles with labels 0..7 in order, then valid_out=0.
REQ-032 rst pulsed 1 cycle while 2 samples are in flight -> no valid_out for either sample; outputs 0.
REQ-033 (ASSIGN_LABEL_CNT_EN) 2100 samples all winning at label 2 -> cnt2 reaches 2047 and stays; clear_cnt asserted coincident with a valid_out -> all counters 0 on the next cycle.
REQ-034 dist7=2^33-2, others 2^33-1 -> label=7, min_dist=8589934590 (full 33-bit compare).
